// File: rtl/dc_pkg.sv
// Shared sizes, entry layout and FIFO thresholds for the 8-to-32 byte packer and its FWFT buffer.
package dc_pkg;
  localparam int SYS_DSIZE = 9;
  localparam int MEM_DSIZE = 36;
  localparam int DEPTH     = 1024;
  localparam int AW        = $clog2(DEPTH);

  // Entry field offsets inside a MEM_DSIZE word.
  localparam int BE_HI   = 35;
  localparam int BE_LO   = 34;
  localparam int EOF_BIT = 33;
  localparam int RSV_BIT = 32;
  localparam int DATA_HI = 31;

  localparam logic [AW:0] AFULL_TH  = (AW+1)'(1020);
  localparam logic [AW:0] AEMPTY_TH = (AW+1)'(4);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

  typedef struct packed {
    logic [1:0]       be;
    logic             eof;
    logic             rsv;
    logic [DATA_HI:0] data;
  } entry_t;
endpackage

// File: rtl/fifo_fwft_36x1024.sv
// First-word-fall-through FIFO: inferred dual-port RAM with a look-ahead output register.
module fifo_fwft_36x1024
  import dc_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 WrEn,
  input  logic [MEM_DSIZE-1:0] Data,
  input  logic                 RdEn,
  output logic [MEM_DSIZE-1:0] Q,
  output logic                 Empty,
  output logic                 Full,
  output logic                 Almost_Full,
  output logic                 Almost_Empty,
  output logic [AW:0]          Wnum
);
  logic [MEM_DSIZE-1:0] r_mem [DEPTH];
  logic [MEM_DSIZE-1:0] r_q;
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic [AW:0]          w_count;
  logic [AW:0]          w_rd_next;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_wr;
  logic                 w_rd;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr      = WrEn & ~w_full;
  assign w_rd      = RdEn & ~w_empty;
  assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_rd};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      r_rd_ptr <= w_rd_next;
    end
  end

  // NOTE: the RAM array has no reset; contents are meaningless until written and a reset would block RAM inference.
  always_ff @(posedge Clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= Data;
  end

  // The output register prefetches the entry after any pop; a write to that same slot is forwarded.
  always_ff @(posedge Clk) begin
    if (w_wr && (r_wr_ptr[AW-1:0] == w_rd_next[AW-1:0])) r_q <= Data;
    else                                                 r_q <= r_mem[w_rd_next[AW-1:0]];
  end

  assign Q            = r_q;
  assign Empty        = ~Reset | w_empty;
  assign Full         = Reset & w_full;
  assign Wnum         = Reset ? w_count : '0;
  assign Almost_Full  = Reset & (w_count >= AFULL_TH);
  assign Almost_Empty = ~Reset | (w_count <= AEMPTY_TH);
endmodule

// File: rtl/dc_8to32_fifo.sv
// Packs a 9-bit {eof, byte} stream into 36-bit little-endian word entries and buffers them in a FWFT FIFO.
module dc_8to32_fifo
  import dc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_vld_i,
  output logic                 s_rdy_o,
  input  logic [SYS_DSIZE-1:0] s_data_i,
  input  logic                 rd_en,
  output logic [MEM_DSIZE-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [AW:0]          wnum
);
  logic [1:0]       r_lane;
  logic [DATA_HI:0] r_word;
  logic             r_pend;
  entry_t           r_pend_entry;
  logic [DATA_HI:0] w_word;
  logic             w_xfer;
  logic             w_done;
  logic             w_wr;

  assign s_rdy_o = rst & (~r_pend | ~full);
  assign w_xfer  = s_vld_i & s_rdy_o;
  assign w_done  = w_xfer & ((r_lane == 2'd3) | s_data_i[8]);
  assign w_wr    = r_pend & ~full;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_word = r_word;
    w_word[{r_lane, 3'b000} +: 8] = s_data_i[7:0];
  end

  // Unused upper lanes stay zero because the partial word is cleared on every completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lane       <= '0;
      r_word       <= '0;
      r_pend       <= 1'b0;
      r_pend_entry <= '0;
    end else begin
      if (w_xfer) begin
        if (w_done) begin
          r_lane <= '0;
          r_word <= '0;
        end else begin
          r_lane <= r_lane + 2'd1;
          r_word <= w_word;
        end
      end
      if (w_done) begin
        r_pend       <= 1'b1;
        r_pend_entry <= '{be: r_lane, eof: s_data_i[8], rsv: 1'b0, data: w_word};
      end else if (w_wr) begin
        r_pend <= 1'b0;
      end
    end
  end

  fifo_fwft_36x1024 u_fifo (
    .Clk          (clk),
    .Reset        (rst),
    .WrEn         (w_wr),
    .Data         (r_pend_entry),
    .RdEn         (rd_en),
    .Q            (rd_data),
    .Empty        (empty),
    .Full         (full),
    .Almost_Full  (almost_full),
    .Almost_Empty (almost_empty),
    .Wnum         (wnum)
  );
endmodule

// File: tb/tb_dc_8to32_fifo.sv
// Directed and randomized checks of dc_8to32_fifo against a frame-level packing model.
module tb_dc_8to32_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_vld_i;
  logic        s_rdy_o;
  logic [8:0]  s_data_i;
  logic        rd_en;
  logic [35:0] rd_data;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic        almost_empty;
  logic [10:0] wnum;

  int n_checks = 0;
  int n_fail   = 0;

  logic [35:0] exp_q[$];
  logic [7:0]  cur_bytes[$];

  always #5 clk = ~clk;

  dc_8to32_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .s_vld_i      (s_vld_i),
    .s_rdy_o      (s_rdy_o),
    .s_data_i     (s_data_i),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .wnum         (wnum)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame model: collect accepted bytes; a word is emitted at 4 bytes or on eof.
  task automatic model_accept(input logic [8:0] d);
    logic [31:0] word;
    int          n;
    cur_bytes.push_back(d[7:0]);
    if (d[8] || cur_bytes.size() == 4) begin
      n    = cur_bytes.size();
      word = '0;
      for (int i = 0; i < n; i++) word[8*i +: 8] = cur_bytes[i];
      exp_q.push_back({2'(n - 1), d[8], 1'b0, word});
      cur_bytes.delete();
    end
  endtask

  // One clock; a pop happening at this edge is checked against the model head.
  task automatic step();
    if (rst && rd_en && !empty) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL pop_extra: observed entry %0h expected none", rd_data);
      end
      if (exp_q.size() != 0) check("pop_data", rd_data, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (rst) begin
      check("afull_flag",  almost_full,  wnum >= 11'd1020);
      check("aempty_flag", almost_empty, wnum <= 11'd4);
      check("full_flag",   full,         wnum == 11'd1024);
      check("empty_flag",  empty,        wnum == 11'd0);
    end
  endtask

  task automatic send(input logic [8:0] d);
    int n = 0;
    s_vld_i  = 1'b1;
    s_data_i = d;
    while (!s_rdy_o && n < 2000) begin
      step();
      n++;
    end
    check("send_ready", s_rdy_o, 1'b1);
    if (s_rdy_o) model_accept(d);
    step();
    s_vld_i = 1'b0;
  endtask

  task automatic wait_nonempty();
    int n = 0;
    while (empty && n < 8) begin
      step();
      n++;
    end
    check("wait_nonempty", empty, 1'b0);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    rd_en = 1'b1;
    while (!empty && n < max_cycles) begin
      step();
      n++;
    end
    rd_en = 1'b0;
    check("drain_empty", empty, 1'b1);
    check("drain_model_empty", exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst      = 1'b0;
    s_vld_i  = 1'b0;
    s_data_i = '0;
    rd_en    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_empty",  empty,        1'b1);
    check("rst_full",   full,         1'b0);
    check("rst_wnum",   wnum,         11'd0);
    check("rst_aempty", almost_empty, 1'b1);
    check("rst_afull",  almost_full,  1'b0);
    check("rst_rdy",    s_rdy_o,      1'b0);
    rst = 1'b1;
    step();
    check("post_rst_rdy", s_rdy_o, 1'b1);

    // Two full words, eof on the eighth byte.
    for (int i = 1; i <= 8; i++) send({(i == 8), 8'(i)});
    wait_nonempty();
    check("fw_word0", rd_data, 36'hC_0403_0201);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("fw_word1", rd_data, 36'hE_0807_0605);
    check("fw_wnum1", wnum, 11'd1);
    drain(4);

    // Two-byte frame: visible two cycles after the eof transfer.
    send(9'h0AA);
    send(9'h1BB);
    check("partial_empty_n1", empty, 1'b1);
    step();
    check("partial_empty_n2", empty, 1'b0);
    check("partial_word", rd_data, 36'h6_0000_BBAA);
    drain(4);

    // Single-byte frame, then a new frame starting from lane 0.
    send(9'h15C);
    wait_nonempty();
    check("single_word", rd_data, 36'h2_0000_005C);
    drain(4);
    send(9'h011);
    send(9'h022);
    send(9'h033);
    send(9'h144);
    wait_nonempty();
    check("after_single_word", rd_data, 36'hE_4433_2211);
    drain(4);

    // Fill with random frames until the pending word is also stuck.
    cyc     = 0;
    s_vld_i = 1'b1;
    while (cyc < 6000) begin
      s_data_i = {($urandom_range(0, 7) == 0), 8'($urandom)};
      if (!s_rdy_o) break;
      model_accept(s_data_i);
      step();
      cyc++;
    end
    check("fill_stall_rdy", s_rdy_o, 1'b0);
    check("fill_wnum", wnum, 11'd1024);
    check("fill_full", full, 1'b1);
    check("fill_afull", almost_full, 1'b1);
    check("fill_model_count", exp_q.size(), 1025);
    repeat (3) step();
    check("fill_hold_rdy", s_rdy_o, 1'b0);
    check("fill_hold_wnum", wnum, 11'd1024);
    s_vld_i = 1'b0;
    rd_en   = 1'b1;
    step();
    rd_en = 1'b0;
    check("pop_one_full", full, 1'b0);
    check("pop_one_wnum", wnum, 11'd1023);
    step();
    check("pending_in_wnum", wnum, 11'd1024);
    check("pending_in_rdy", s_rdy_o, 1'b1);
    drain(1100);
    send({1'b1, 8'hA5});
    wait_nonempty();
    drain(8);

    // Concurrent streaming with rd_en held high.
    rd_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send({($urandom_range(0, 5) == 0), 8'($urandom)});
      check("conc_wnum_le1", (wnum <= 11'd1), 1'b1);
    end
    send({1'b1, 8'h3C});
    repeat (6) step();
    check("conc_model_empty", exp_q.size(), 0);
    check("conc_empty", empty, 1'b1);
    rd_en = 1'b0;

    // Reset mid-frame with an entry already buffered.
    send(9'h001);
    send(9'h002);
    send(9'h003);
    send(9'h004);
    send(9'h031);
    send(9'h032);
    check("pre_rst_nonempty", empty, 1'b0);
    rst = 1'b0;
    step();
    check("midrst_rdy",   s_rdy_o, 1'b0);
    check("midrst_empty", empty,   1'b1);
    check("midrst_wnum",  wnum,    11'd0);
    exp_q.delete();
    cur_bytes.delete();
    rst = 1'b1;
    step();
    check("postrst_empty", empty, 1'b1);
    check("postrst_wnum",  wnum,  11'd0);
    send(9'h041);
    send(9'h042);
    send(9'h043);
    send(9'h144);
    wait_nonempty();
    check("postrst_word", rd_data, 36'hE_4443_4241);
    check("postrst_wnum1", wnum, 11'd1);
    drain(4);
    repeat (3) step();
    check("postrst_no_extra", empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
